// File: rtl/yarp_dmem_ctrl.sv
// Data-memory controller between the core load/store port and a single-port SRAM.
// Latency: aligned access ready 2+WAIT_CYCLES cycles after acceptance, misaligned 1.
// Backpressure: one request in flight; req_i is ignored outside IDLE, held by core until ready_o.
module yarp_dmem_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_i,
  input  logic [31:0]              addr_i,
  input  logic [1:0]               byte_en_i,
  input  logic                     wr_i,
  input  logic [31:0]              wr_data_i,
  output logic                     ready_o,
  output logic [31:0]              rd_data_o,
  output logic                     err_o,
  output logic                     sram_cs_o,
  output logic                     sram_we_o,
  output logic [$clog2(DEPTH)-1:0] sram_addr_o,
  output logic [3:0]               sram_wmask_o,
  output logic [31:0]              sram_wdata_o,
  input  logic [31:0]              sram_rdata_i
);

  localparam int AW = $clog2(DEPTH);

  // access-size encodings on byte_en_i; 2'b10 is reserved and always errors
  localparam logic [1:0] BE_BYTE = 2'b00;
  localparam logic [1:0] BE_HALF = 2'b01;
  localparam logic [1:0] BE_WORD = 2'b11;

  // the wait counter runs from WAIT_CYCLES-1 down to 0 inclusive
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // captured request; only the address bits that reach the SRAM are kept
  logic [AW+1:0] addr_q;
  logic [1:0]    be_q;
  logic          wr_q;
  logic [31:0]   wdata_q;

  logic [3:0]    cnt;
  logic [31:0]   rd_data_q;
  logic          err_q;

  logic          accept;
  logic          misaligned_in;
  logic          rd_capture;
  logic [3:0]    lane_mask;
  logic [31:0]   lane_wdata;
  logic [31:0]   rd_shifted;

  // address bits above the SRAM word index wrap and are deliberately dropped
  logic          unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:AW+2];

  assign accept     = (state == ST_IDLE) && req_i;
  assign rd_capture = (state == ST_WAIT) && (cnt == 4'd0);

  // Alignment is judged on the live request because the branch to RESP is taken at acceptance
  always_comb begin
    misaligned_in = 1'b0;
    case (byte_en_i)
      BE_BYTE: misaligned_in = 1'b0;
      BE_HALF: misaligned_in = addr_i[0];
      BE_WORD: misaligned_in = (addr_i[1:0] != 2'b00);
      default: misaligned_in = 1'b1;
    endcase
  end

  // Byte-lane mask for the captured access size and offset
  always_comb begin
    lane_mask = 4'b0000;
    case (be_q)
      BE_BYTE: lane_mask = 4'b0001 << addr_q[1:0];
      BE_HALF: lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
      BE_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  end

  // Replicate store data across lanes so the mask alone selects the target bytes
  always_comb begin
    lane_wdata = wdata_q;
    case (be_q)
      BE_BYTE: lane_wdata = {4{wdata_q[7:0]}};
      BE_HALF: lane_wdata = {2{wdata_q[15:0]}};
      default: lane_wdata = wdata_q;
    endcase
  end

  // Right-justify the addressed lane; upper bits keep the raw neighbouring lanes
  assign rd_shifted = sram_rdata_i >> {addr_q[1:0], 3'b000};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_i) begin
          state_nxt = misaligned_in ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Per-state outputs; the SRAM sees a strobe only during ACCESS
  always_comb begin
    ready_o      = 1'b0;
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_wmask_o = 4'b0000;
    case (state)
      ST_ACCESS: begin
        sram_cs_o    = 1'b1;
        sram_we_o    = wr_q;
        sram_wmask_o = lane_mask;
      end
      ST_RESP: ready_o = 1'b1;
      default: ;
    endcase
  end

  // Capture the request fields at acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      be_q    <= 2'b00;
      wr_q    <= 1'b0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      addr_q  <= addr_i[AW+1:0];
      be_q    <= byte_en_i;
      wr_q    <= wr_i;
      wdata_q <= wr_data_i;
    end
  end

  // Wait counter: armed in ACCESS, counts down through WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (state == ST_ACCESS) begin
      cnt <= WAIT_INIT;
    end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response registers are only rewritten on the way into RESP so they hold between responses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= 32'd0;
      err_q     <= 1'b0;
    end else if (accept && misaligned_in) begin
      rd_data_q <= 32'd0;
      err_q     <= 1'b1;
    end else if (rd_capture) begin
      rd_data_q <= wr_q ? 32'd0 : rd_shifted;
      err_q     <= 1'b0;
    end
  end

  assign rd_data_o    = rd_data_q;
  assign err_o        = err_q;
  assign sram_addr_o  = addr_q[AW+1:2];
  assign sram_wdata_o = lane_wdata;

endmodule

// File: tb/tb_yarp_dmem_ctrl.sv
module tb_yarp_dmem_ctrl;

  localparam int DEPTH_A = 64;
  localparam int WC_A    = 1;
  localparam int DEPTH_B = 16;
  localparam int WC_B    = 4;

  logic clk;
  logic reset;

  // DUT A: small SRAM, single wait cycle
  logic        a_req, a_wr, a_ready, a_err, a_cs, a_we;
  logic [31:0] a_addr, a_wdata, a_rd, a_wdat, a_rdat;
  logic [1:0]  a_be;
  logic [5:0]  a_saddr;
  logic [3:0]  a_wmask;

  // DUT B: tiny SRAM, four wait cycles, used for wrap and throughput
  logic        b_req, b_wr, b_ready, b_err, b_cs, b_we;
  logic [31:0] b_addr, b_wdata, b_rd, b_wdat, b_rdat;
  logic [1:0]  b_be;
  logic [3:0]  b_saddr;
  logic [3:0]  b_wmask;

  int vectors;
  int miscompares;

  logic [31:0] mem_a [DEPTH_A];
  logic [31:0] mem_b [DEPTH_B];
  logic [7:0]  ref_a [4*DEPTH_A];
  logic [7:0]  ref_b [4*DEPTH_B];

  yarp_dmem_ctrl #(.DEPTH(DEPTH_A), .WAIT_CYCLES(WC_A)) dut_a (
    .clk(clk), .reset(reset), .req_i(a_req), .addr_i(a_addr), .byte_en_i(a_be),
    .wr_i(a_wr), .wr_data_i(a_wdata), .ready_o(a_ready), .rd_data_o(a_rd),
    .err_o(a_err), .sram_cs_o(a_cs), .sram_we_o(a_we), .sram_addr_o(a_saddr),
    .sram_wmask_o(a_wmask), .sram_wdata_o(a_wdat), .sram_rdata_i(a_rdat)
  );

  yarp_dmem_ctrl #(.DEPTH(DEPTH_B), .WAIT_CYCLES(WC_B)) dut_b (
    .clk(clk), .reset(reset), .req_i(b_req), .addr_i(b_addr), .byte_en_i(b_be),
    .wr_i(b_wr), .wr_data_i(b_wdata), .ready_o(b_ready), .rd_data_o(b_rd),
    .err_o(b_err), .sram_cs_o(b_cs), .sram_we_o(b_we), .sram_addr_o(b_saddr),
    .sram_wmask_o(b_wmask), .sram_wdata_o(b_wdat), .sram_rdata_i(b_rdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM A: masked write on the strobe edge, read data registered and held
  always @(posedge clk) begin
    if (a_cs) begin
      if (a_we) begin
        for (int i = 0; i < 4; i++) if (a_wmask[i]) mem_a[a_saddr][8*i +: 8] <= a_wdat[8*i +: 8];
      end else begin
        a_rdat <= mem_a[a_saddr];
      end
    end
  end

  // SRAM B: same behaviour
  always @(posedge clk) begin
    if (b_cs) begin
      if (b_we) begin
        for (int i = 0; i < 4; i++) if (b_wmask[i]) mem_b[b_saddr][8*i +: 8] <= b_wdat[8*i +: 8];
      end else begin
        b_rdat <= mem_b[b_saddr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [1:0] be);
    case (be)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic misaligned(input logic [31:0] addr, input logic [1:0] be);
    if (be == 2'b10) return 1'b1;
    return (int'(addr[1:0]) % size_of(be)) != 0;
  endfunction

  // One complete transaction on DUT A, checked against the byte-level memory model.
  // Entered at a falling edge with the DUT idle; returns one cycle after the response.
  task automatic txn_a(input logic [31:0] addr, input logic [1:0] be, input logic w,
                       input logic [31:0] d, output logic [31:0] got_rd);
    int          sz, ba, off, cs_k, cs_n, rdy_k;
    logic        mis, got_err, s_we;
    logic [31:0] exp_rd, s_addr, s_wdat, exp_wdat;
    logic [3:0]  s_mask, exp_mask;
    sz  = size_of(be);
    mis = misaligned(addr, be);
    ba  = int'(addr[7:0]);
    off = ba % 4;
    exp_rd = 32'd0; exp_mask = 4'd0; exp_wdat = 32'd0;
    if (!mis && !w) for (int k = 0; k < 4 - off; k++) exp_rd |= 32'(ref_a[ba+k]) << (8*k);
    if (!mis) for (int k = 0; k < sz; k++) exp_mask[off+k] = 1'b1;
    for (int j = 0; j < 4; j++) exp_wdat[8*j +: 8] = d[8*(j % sz) +: 8];
    if (!mis && w) for (int k = 0; k < sz; k++) ref_a[ba+k] = d[8*k +: 8];

    a_addr = addr; a_be = be; a_wr = w; a_wdata = d; a_req = 1'b1;
    cs_n = 0; cs_k = -1; rdy_k = -1; got_rd = 32'd0; got_err = 1'b0;
    s_we = 1'b0; s_addr = 32'd0; s_mask = 4'd0; s_wdat = 32'd0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (a_cs) begin
        cs_n++; cs_k = k; s_we = a_we; s_addr = 32'(a_saddr); s_mask = a_wmask; s_wdat = a_wdat;
      end
      if (a_ready) begin
        rdy_k = k; got_rd = a_rd; got_err = a_err;
        break;
      end
    end
    a_req = 1'b0;

    check("latency", rdy_k, mis ? 1 : 2 + WC_A);
    check("cs_count", cs_n, mis ? 0 : 1);
    check("err", got_err, mis);
    check("rd_data", got_rd, exp_rd);
    if (!mis) begin
      check("cs_cycle", cs_k, 1);
      check("sram_addr", s_addr, (addr >> 2) & (DEPTH_A - 1));
      check("sram_we", s_we, w);
      if (w) begin
        check("wmask", s_mask, exp_mask);
        check("wdata", s_wdat, exp_wdat);
      end
    end
    @(negedge clk);
    check("ready_width", a_ready, 1'b0);
    check("rd_hold", a_rd, exp_rd);
    check("err_hold", a_err, mis);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] rd, exp_b, addr, w32;
    logic [1:0]  be;
    int          nrdy;
    int          rdy_t [3];

    vectors = 0; miscompares = 0;
    reset = 1'b0;
    a_req = 1'b0; a_addr = 32'd0; a_be = 2'b00; a_wr = 1'b0; a_wdata = 32'd0;
    b_req = 1'b0; b_addr = 32'd0; b_be = 2'b00; b_wr = 1'b0; b_wdata = 32'd0;
    a_rdat = 32'd0; b_rdat = 32'd0;
    for (int i = 0; i < DEPTH_A; i++) begin
      w32 = $urandom;
      mem_a[i] = w32;
      for (int k = 0; k < 4; k++) ref_a[4*i+k] = w32[8*k +: 8];
    end
    for (int i = 0; i < DEPTH_B; i++) begin
      w32 = $urandom;
      mem_b[i] = w32;
      for (int k = 0; k < 4; k++) ref_b[4*i+k] = w32[8*k +: 8];
    end

    // reset state
    #2 reset = 1'b1;
    #1;
    check("rst_ready", a_ready, 1'b0);
    check("rst_err", a_err, 1'b0);
    check("rst_rd", a_rd, 32'd0);
    check("rst_cs", a_cs, 1'b0);
    check("rst_we", a_we, 1'b0);
    check("rst_wmask", a_wmask, 4'd0);
    check("rst_saddr", a_saddr, 6'd0);
    check("rst_wdata", a_wdat, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // back-to-back loads on B at an address that wraps to word 0
    exp_b = {ref_b[3], ref_b[2], ref_b[1], ref_b[0]};
    b_addr = 32'h4000 + 32'(4 * (DEPTH_B - 1)) + 32'd4;
    b_be = 2'b11; b_wr = 1'b0; b_req = 1'b1;
    nrdy = 0;
    for (int i = 0; i < 3; i++) rdy_t[i] = -100;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (b_cs) check("b_wrap_addr", 32'(b_saddr), 32'd0);
      if (b_ready) begin
        if (nrdy < 3) rdy_t[nrdy] = k;
        nrdy++;
        check("b_rd", b_rd, exp_b);
        check("b_err", b_err, 1'b0);
      end
    end
    b_req = 1'b0;
    check("b_ready_count", nrdy, 3);
    check("b_first_ready", rdy_t[0], 2 + WC_B);
    check("b_period_1", rdy_t[1] - rdy_t[0], WC_B + 3);
    check("b_period_2", rdy_t[2] - rdy_t[1], WC_B + 3);

    // directed word store / load
    txn_a(32'h10, 2'b11, 1'b1, 32'hDEADBEEF, rd);
    txn_a(32'h10, 2'b11, 1'b0, $urandom, rd);
    check("word_load", rd, 32'hDEADBEEF);

    // byte store into lane 3, then byte load
    txn_a(32'h10, 2'b11, 1'b1, 32'h00BEEF00, rd);
    txn_a(32'h13, 2'b00, 1'b1, 32'h000000A5, rd);
    txn_a(32'h13, 2'b00, 1'b0, $urandom, rd);
    check("byte_load", rd, 32'h000000A5);

    // half-word load from the upper half
    txn_a(32'h20, 2'b11, 1'b1, 32'h80011234, rd);
    txn_a(32'h22, 2'b01, 1'b0, $urandom, rd);
    check("half_load", rd, 32'h00008001);

    // misaligned and reserved accesses, including stores that must not land
    txn_a(32'h06, 2'b11, 1'b0, $urandom, rd);
    txn_a(32'h05, 2'b01, 1'b0, $urandom, rd);
    txn_a(32'h12, 2'b11, 1'b1, 32'hFFFFFFFF, rd);
    txn_a(32'h11, 2'b01, 1'b1, 32'hFFFFFFFF, rd);
    txn_a(32'h10, 2'b10, 1'b1, 32'hFFFFFFFF, rd);
    txn_a(32'h10, 2'b11, 1'b0, $urandom, rd);
    check("mis_no_write", rd, 32'hA5BEEF00);

    // reset in the WAIT cycle of a load
    a_addr = 32'h10; a_be = 2'b11; a_wr = 1'b0; a_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; a_req = 1'b0;
    #1;
    check("mid_rst_ready", a_ready, 1'b0);
    check("mid_rst_err", a_err, 1'b0);
    check("mid_rst_rd", a_rd, 32'd0);
    check("mid_rst_cs", a_cs, 1'b0);
    check("mid_rst_saddr", a_saddr, 6'd0);
    check("mid_rst_wdata", a_wdat, 32'd0);
    nrdy = 0;
    repeat (3) begin
      @(negedge clk);
      if (a_ready) nrdy++;
    end
    check("mid_rst_no_ready", nrdy, 0);
    reset = 1'b0;
    txn_a(32'h10, 2'b11, 1'b0, $urandom, rd);
    check("post_rst_load", rd, 32'hA5BEEF00);

    // randomized traffic, including addresses beyond the SRAM that wrap
    for (int n = 0; n < 80; n++) begin
      be   = 2'($urandom_range(0, 3));
      addr = 32'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(size_of(be) - 1);
      txn_a(addr, be, 1'($urandom_range(0, 1)), $urandom, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/yarp_dmem_ctrl.md
YARP_DMEM_CTRL -- requirements
Module: yarp_dmem_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning data SRAM size in 32-bit words (power of 2, >= 4); AW = log2(DEPTH).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, meaning SRAM read latency in cycles after chip-select (legal 1..15).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port req_i, input, 1, core request; held high with all request fields stable until ready_o.
REQ-006 The block SHALL have port addr_i, input, 32, byte address.
REQ-007 The block SHALL have port byte_en_i, input, 2, access size: BYTE=2'b00, HALF_WORD=2'b01, WORD=2'b11; 2'b10 is reserved.
REQ-008 The block SHALL have port wr_i, input, 1, 1=store, 0=load.
REQ-009 The block SHALL have port wr_data_i, input, 32, store data, right-justified.
REQ-010 The block SHALL have port ready_o, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have port rd_data_o, output, 32, load data shifted to bit 0, unextended; valid when ready_o=1.
REQ-012 The block SHALL have port err_o, output, 1, misaligned or reserved-size access; valid when ready_o=1.
REQ-013 The block SHALL have ports sram_cs_o (output, 1, chip-select), sram_we_o (output, 1, write enable), sram_addr_o (output, AW, word index), sram_wmask_o (output, 4, byte-lane mask), sram_wdata_o (output, 32, lane-steered write data), sram_rdata_i (input, 32, read word).

Function
REQ-014 The FSM SHALL have states IDLE, ACCESS, WAIT, RESP.
REQ-015 In IDLE with req_i=1 at a rising edge, the block SHALL capture addr_i, byte_en_i, wr_i and wr_data_i; req_i outside IDLE is ignored.
REQ-016 A captured request SHALL be misaligned when byte_en=2'b10, HALF_WORD with addr[0]=1, or WORD with addr[1:0]!=0.
REQ-017 A misaligned request SHALL go IDLE->RESP with no SRAM activity; in RESP: ready_o=1, err_o=1, rd_data_o=0; a misaligned store SHALL NOT alter memory.
REQ-018 An aligned request SHALL go IDLE->ACCESS (1 cycle) ->WAIT (WAIT_CYCLES cycles, counter from WAIT_CYCLES-1 down to 0) ->RESP (1 cycle) ->IDLE.
REQ-019 Latency: request accepted at end of cycle N -> ACCESS in N+1, RESP (ready_o=1) in N+2+WAIT_CYCLES for loads and stores alike; misaligned -> RESP in N+1.
REQ-020 sram_cs_o=1 only in ACCESS; sram_we_o=captured wr only in ACCESS, else 0.
REQ-021 sram_addr_o SHALL be captured addr[AW+1:2]; higher address bits ignored (wrap modulo DEPTH).
REQ-022 sram_wmask_o SHALL be: BYTE -> 4'b0001 << addr[1:0]; HALF_WORD -> 4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1); WORD -> 4'b1111.
REQ-023 sram_wdata_o SHALL replicate wr_data[7:0] x4 (BYTE), wr_data[15:0] x2 (HALF_WORD), wr_data (WORD).
REQ-024 On the final WAIT cycle edge the block SHALL register sram_rdata_i >> (8*addr[1:0]) with zero fill into the rd_data_o register; stores load 0.
REQ-025 rd_data_o and err_o SHALL hold their values until the next RESP; ready_o SHALL be exactly one cycle wide.
REQ-026 The block SHALL NOT sign- or zero-extend by size; upper bits of rd_data_o are raw shifted lanes (extension is downstream's job).
REQ-027 req_i high during RESP SHALL NOT be accepted that cycle; acceptance resumes in the following IDLE cycle (one request per WAIT_CYCLES+3 cycles).

Reset
REQ-028 Reset assertion SHALL immediately force IDLE, ready_o=0, err_o=0, rd_data_o=0, sram_cs_o=0, sram_we_o=0, sram_wmask_o=0, sram_addr_o=0, sram_wdata_o=0, counter=0.
REQ-029 Reset mid-transaction SHALL abandon it with no ready_o; a store already past ACCESS remains written.
REQ-030 After deassertion, the first request SHALL be accepted on the first rising edge with req_i=1.

Verification
REQ-031 WAIT_CYCLES=1: store WORD 0xDEADBEEF @0x10, then load WORD @0x10 -> cs in N+1, wmask 4'b1111, sram_addr 4, ready_o in N+3, rd_data_o=0xDEADBEEF, err_o=0.
REQ-032 Store BYTE 0x000000A5 @0x13 -> wmask 4'b1000, wdata 0xA5A5A5A5; later load BYTE @0x13 with word 0xA5BEEF00 -> rd_data_o=0x000000A5.
REQ-033 Load HALF_WORD @0x22 of word 0x8001_1234 -> wmask unused, rd_data_o=0x00008001, err_o=0.
REQ-034 Load WORD @0x06 and HALF_WORD @0x05 -> no cs, ready_o in N+1, err_o=1, rd_data_o=0; memory unchanged.
REQ-035 Reset asserted during WAIT of a load -> outputs zero immediately, no ready_o; new load after release completes normally.
REQ-036 WAIT_CYCLES=4 with back-to-back requests and address 0x4000+4*(DEPTH-1)+4 -> ready_o every 7 cycles, sram_addr wraps to 0.
